// File: rtl/relu_act_pipe_if.sv
// ============================================================================
// Module : relu_act_pipe_if
// Brief  : Input/output stream bundle for the activation pipeline.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface relu_act_pipe_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
);
  logic [1:0]              mode;
  logic                    s_valid;
  logic                    s_ready;
  logic [LANES*DATA_W-1:0] s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic [LANES*DATA_W-1:0] m_data;

  modport master (
    output mode, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  mode, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

`default_nettype wire

// File: rtl/relu_act_pipe.sv
// ============================================================================
// Module : relu_act_pipe
// Brief  : Two-stage multi-lane ReLU / leaky / clipped / bypass activation
//          with a saturating negative-lane counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module relu_act_pipe #(
  parameter int                DATA_W      = 16,
  parameter int                LANES       = 4,
  parameter int                LEAKY_SHIFT = 3,
  parameter logic [DATA_W-1:0] CLIP_MAX    = 16'h0600,
  parameter int                CNT_W       = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  relu_act_pipe_if.slave        strm,
  input  wire logic             stat_clr,
  output logic [CNT_W-1:0]      neg_cnt
);

  localparam int C_BUS_W = LANES * DATA_W;
  localparam int C_NEG_W = $clog2(LANES + 1);
  localparam int C_SUM_W = CNT_W + C_NEG_W;

  logic               rdy_q;
  logic               v1_q, v1_d;
  logic [C_BUS_W-1:0] d1_q, d1_d;
  logic [1:0]         mode1_q, mode1_d;
  logic               v2_q, v2_d;
  logic [C_BUS_W-1:0] d2_q, d2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_adv1, w_adv2, w_acc;
  logic [C_BUS_W-1:0] w_act;
  logic [C_NEG_W-1:0] w_negs, w_add;
  logic [CNT_W-1:0]   w_base;
  logic [C_SUM_W-1:0] w_sum;

  function automatic logic [DATA_W-1:0] act_lane(input logic [1:0] m,
                                                 input logic [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] sx;
    logic signed [DATA_W-1:0] shf;
    logic                     neg;
    sx  = x;
    shf = sx >>> LEAKY_SHIFT;
    neg = x[DATA_W-1];
    case (m)
      2'd0:    act_lane = neg ? '0 : x;
      2'd1:    act_lane = neg ? shf : x;
      2'd2:    act_lane = neg ? '0 : (($signed(x) > $signed(CLIP_MAX)) ? CLIP_MAX : x);
      default: act_lane = x;
    endcase
  endfunction

  // rdy_q keeps s_ready low during reset and for the first cycle after it.
  assign w_adv2       = !v2_q || strm.m_ready;
  assign w_adv1       = !v1_q || w_adv2;
  assign strm.s_ready = rdy_q && w_adv1;
  assign w_acc        = strm.s_valid && strm.s_ready;

  always_comb begin
    w_act = '0;
    for (int i = 0; i < LANES; i++) begin
      w_act[i*DATA_W +: DATA_W] = act_lane(mode1_q, d1_q[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    w_negs = '0;
    for (int i = 0; i < LANES; i++) begin
      w_negs = w_negs + C_NEG_W'(strm.s_data[i*DATA_W + DATA_W - 1]);
    end
  end

  // Clear and accept in the same cycle restart the count from this beat.
  assign w_base = stat_clr ? '0 : cnt_q;
  assign w_add  = w_acc ? w_negs : '0;
  assign w_sum  = C_SUM_W'(w_base) + C_SUM_W'(w_add);
  assign cnt_d  = (|w_sum[C_SUM_W-1:CNT_W]) ? '1 : w_sum[CNT_W-1:0];

  always_comb begin
    v1_d    = v1_q;
    d1_d    = d1_q;
    mode1_d = mode1_q;
    v2_d    = v2_q;
    d2_d    = d2_q;
    if (w_adv1) begin
      v1_d = w_acc;
      if (w_acc) begin
        d1_d    = strm.s_data;
        mode1_d = strm.mode;
      end
    end
    if (w_adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        d2_d = w_act;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      v1_q    <= 1'b0;
      d1_q    <= '0;
      mode1_q <= 2'd0;
      v2_q    <= 1'b0;
      d2_q    <= '0;
      cnt_q   <= '0;
    end else begin
      rdy_q   <= 1'b1;
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      mode1_q <= mode1_d;
      v2_q    <= v2_d;
      d2_q    <= d2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign strm.m_valid = v2_q;
  assign strm.m_data  = d2_q;
  assign neg_cnt      = cnt_q;

endmodule

`default_nettype wire
